// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback-side bundle of the register bank: read ports, issue reservation,
// writeback strobe and scoreboard status.
interface regfile_scoreboard_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 2
);
   logic [ADDR_W-1:0]      rd_addr_a;
   logic [ADDR_W-1:0]      rd_addr_b;
   logic [DATA_W-1:0]      rd_data_a;
   logic [DATA_W-1:0]      rd_data_b;
   logic                   rd_busy_a;
   logic                   rd_busy_b;
   logic                   iss_valid;
   logic [ADDR_W-1:0]      iss_addr;
   logic                   iss_ready;
   logic                   wb_valid;
   logic [ADDR_W-1:0]      wb_addr;
   logic [DATA_W-1:0]      wb_data;
   logic [(1<<ADDR_W)-1:0] busy_vec;
   logic [ADDR_W:0]        pending_cnt;
   logic                   wb_stray;

   modport master (
      output rd_addr_a, rd_addr_b, iss_valid, iss_addr, wb_valid, wb_addr, wb_data,
      input  rd_data_a, rd_data_b, rd_busy_a, rd_busy_b, iss_ready,
             busy_vec, pending_cnt, wb_stray
   );

   modport slave (
      input  rd_addr_a, rd_addr_b, iss_valid, iss_addr, wb_valid, wb_addr, wb_data,
      output rd_data_a, rd_data_b, rd_busy_a, rd_busy_b, iss_ready,
             busy_vec, pending_cnt, wb_stray
   );
endinterface

// File: rtl/regfile_scoreboard.sv
// 2-read/1-write register bank with a per-register busy scoreboard, writeback-to-read
// bypass and an optional hardwired zero register.
module regfile_scoreboard #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 2,
   parameter int ZERO_REG = 0,
   parameter int BYPASS   = 1
) (
   input  logic               clock,
   input  logic               reset,
   regfile_scoreboard_if.slave bus
);
   localparam int NREGS = 1 << ADDR_W;

   logic [DATA_W-1:0] regs [NREGS];
   logic [NREGS-1:0]  busy_q;
   logic              wb_stray_q;

   logic              wb_zero, iss_zero, rd_zero_a, rd_zero_b;
   logic              wb_en, iss_acc, hit_a, hit_b;
   logic [ADDR_W:0]   cnt;

   assign wb_zero   = (ZERO_REG != 0) && (bus.wb_addr   == '0);
   assign iss_zero  = (ZERO_REG != 0) && (bus.iss_addr  == '0);
   assign rd_zero_a = (ZERO_REG != 0) && (bus.rd_addr_a == '0);
   assign rd_zero_b = (ZERO_REG != 0) && (bus.rd_addr_b == '0);

   assign wb_en         = bus.wb_valid && !wb_zero;
   // The zero register is never busy, so this also accepts every issue to it.
   assign bus.iss_ready = !busy_q[bus.iss_addr] || (bus.wb_valid && (bus.wb_addr == bus.iss_addr));
   assign iss_acc       = bus.iss_valid && bus.iss_ready && !iss_zero;

   assign hit_a = (BYPASS != 0) && bus.wb_valid && (bus.wb_addr == bus.rd_addr_a) && !rd_zero_a;
   assign hit_b = (BYPASS != 0) && bus.wb_valid && (bus.wb_addr == bus.rd_addr_b) && !rd_zero_b;

   assign bus.rd_data_a = rd_zero_a ? '0 : (hit_a ? bus.wb_data : regs[bus.rd_addr_a]);
   assign bus.rd_data_b = rd_zero_b ? '0 : (hit_b ? bus.wb_data : regs[bus.rd_addr_b]);
   assign bus.rd_busy_a = busy_q[bus.rd_addr_a] && !hit_a;
   assign bus.rd_busy_b = busy_q[bus.rd_addr_b] && !hit_b;

   // NOTE: the register file itself is reset because a reset bank must read back as zero;
   // storage that only needs valid data after a write would normally be left unreset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
         busy_q     <= '0;
         wb_stray_q <= 1'b0;
      end else begin
         // NOTE: state uses non-blocking assignments so every flop samples pre-edge values;
         // the issue set is placed after the writeback clear so the new producer wins.
         if (wb_en) begin
            regs[bus.wb_addr]   <= bus.wb_data;
            busy_q[bus.wb_addr] <= 1'b0;
            if (!busy_q[bus.wb_addr]) wb_stray_q <= 1'b1;
         end
         if (iss_acc) busy_q[bus.iss_addr] <= 1'b1;
      end
   end

   // NOTE: cnt is cleared before the loop so the combinational block cannot infer a latch.
   always_comb begin
      cnt = '0;
      for (int i = 0; i < NREGS; i++) cnt = cnt + {{ADDR_W{1'b0}}, busy_q[i]};
   end

   assign bus.busy_vec    = busy_q;
   assign bus.pending_cnt = cnt;
   assign bus.wb_stray    = wb_stray_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: default build, ZERO_REG=1 build and BYPASS=0 build
// share one clock and reset.
module tb_regfile_scoreboard;
   logic clock;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   regfile_scoreboard_if #(.DATA_W(16), .ADDR_W(2)) b0 ();
   regfile_scoreboard_if #(.DATA_W(16), .ADDR_W(2)) bz ();
   regfile_scoreboard_if #(.DATA_W(16), .ADDR_W(2)) bn ();

   regfile_scoreboard #(.DATA_W(16), .ADDR_W(2), .ZERO_REG(0), .BYPASS(1))
      u_dut  (.clock(clock), .reset(reset), .bus(b0));
   regfile_scoreboard #(.DATA_W(16), .ADDR_W(2), .ZERO_REG(1), .BYPASS(1))
      u_zero (.clock(clock), .reset(reset), .bus(bz));
   regfile_scoreboard #(.DATA_W(16), .ADDR_W(2), .ZERO_REG(0), .BYPASS(0))
      u_nb   (.clock(clock), .reset(reset), .bus(bn));

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Inputs change 2 time units after a rising edge, well clear of the next one.
   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic idle_all();
      b0.rd_addr_a = '0; b0.rd_addr_b = '0; b0.iss_valid = 1'b0; b0.iss_addr = '0;
      b0.wb_valid = 1'b0; b0.wb_addr = '0; b0.wb_data = '0;
      bz.rd_addr_a = '0; bz.rd_addr_b = '0; bz.iss_valid = 1'b0; bz.iss_addr = '0;
      bz.wb_valid = 1'b0; bz.wb_addr = '0; bz.wb_data = '0;
      bn.rd_addr_a = '0; bn.rd_addr_b = '0; bn.iss_valid = 1'b0; bn.iss_addr = '0;
      bn.wb_valid = 1'b0; bn.wb_addr = '0; bn.wb_data = '0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      idle_all();
      tick();
      for (int i = 0; i < 4; i++) begin
         b0.rd_addr_a = 2'(i);
         #1;
         checks++;
         if (b0.rd_data_a !== 16'h0000) begin
            errors++; $display("FAIL reset_read r%0d: got %h want 0000", i, b0.rd_data_a);
         end
      end
      checks++;
      if (b0.busy_vec !== 4'b0000) begin errors++; $display("FAIL reset_busy_vec: got %b want 0000", b0.busy_vec); end
      checks++;
      if (b0.pending_cnt !== 3'd0) begin errors++; $display("FAIL reset_pending_cnt: got %0d want 0", b0.pending_cnt); end
      checks++;
      if (b0.wb_stray !== 1'b0) begin errors++; $display("FAIL reset_wb_stray: got %b want 0", b0.wb_stray); end

      // Reset asserted while an issue and a stray writeback are being presented.
      reset = 1'b1;
      b0.rd_addr_a = '0;
      tick();
      b0.iss_valid = 1'b1; b0.iss_addr = 2'd2;
      b0.wb_valid = 1'b1; b0.wb_addr = 2'd3; b0.wb_data = 16'h5555;
      #1;
      reset = 1'b0;
      tick();
      b0.iss_valid = 1'b0; b0.wb_valid = 1'b0; b0.rd_addr_b = 2'd3;
      #1;
      checks++;
      if (b0.busy_vec !== 4'b0000) begin errors++; $display("FAIL midreset_busy_vec: got %b want 0000", b0.busy_vec); end
      checks++;
      if (b0.wb_stray !== 1'b0) begin errors++; $display("FAIL midreset_wb_stray: got %b want 0", b0.wb_stray); end
      checks++;
      if (b0.rd_data_b !== 16'h0000) begin errors++; $display("FAIL midreset_r3: got %h want 0000", b0.rd_data_b); end
      checks++;
      if (b0.pending_cnt !== 3'd0) begin errors++; $display("FAIL midreset_pending_cnt: got %0d want 0", b0.pending_cnt); end
      reset = 1'b1;
      idle_all();
      tick();
   endtask

   task automatic test_issue_writeback();
      b0.iss_valid = 1'b1; b0.iss_addr = 2'd2;
      #1;
      checks++;
      if (b0.iss_ready !== 1'b1) begin errors++; $display("FAIL iss_r2_ready: got %b want 1", b0.iss_ready); end
      tick();
      b0.iss_valid = 1'b0; b0.rd_addr_a = 2'd2;
      #1;
      checks++;
      if (b0.rd_busy_a !== 1'b1) begin errors++; $display("FAIL iss_r2_rd_busy: got %b want 1", b0.rd_busy_a); end
      checks++;
      if (b0.pending_cnt !== 3'd1) begin errors++; $display("FAIL iss_r2_pending_cnt: got %0d want 1", b0.pending_cnt); end
      checks++;
      if (b0.busy_vec !== 4'b0100) begin errors++; $display("FAIL iss_r2_busy_vec: got %b want 0100", b0.busy_vec); end
      b0.wb_valid = 1'b1; b0.wb_addr = 2'd2; b0.wb_data = 16'hBEEF;
      #1;
      checks++;
      if (b0.rd_data_a !== 16'hBEEF) begin errors++; $display("FAIL bypass_r2_data: got %h want beef", b0.rd_data_a); end
      checks++;
      if (b0.rd_busy_a !== 1'b0) begin errors++; $display("FAIL bypass_r2_busy: got %b want 0", b0.rd_busy_a); end
      tick();
      b0.wb_valid = 1'b0;
      #1;
      checks++;
      if (b0.busy_vec !== 4'b0000) begin errors++; $display("FAIL wb_r2_busy_vec: got %b want 0000", b0.busy_vec); end
      checks++;
      if (b0.rd_data_a !== 16'hBEEF) begin errors++; $display("FAIL wb_r2_stored: got %h want beef", b0.rd_data_a); end
      checks++;
      if (b0.wb_stray !== 1'b0) begin errors++; $display("FAIL wb_r2_stray: got %b want 0", b0.wb_stray); end
   endtask

   task automatic test_back_to_back();
      b0.iss_valid = 1'b1; b0.iss_addr = 2'd1;
      #1;
      checks++;
      if (b0.iss_ready !== 1'b1) begin errors++; $display("FAIL iss_r1_first_ready: got %b want 1", b0.iss_ready); end
      tick();
      #1;
      checks++;
      if (b0.iss_ready !== 1'b0) begin errors++; $display("FAIL iss_r1_second_ready: got %b want 0", b0.iss_ready); end
      tick();
      checks++;
      if (b0.pending_cnt !== 3'd1) begin errors++; $display("FAIL iss_r1_stall_cnt: got %0d want 1", b0.pending_cnt); end
      b0.wb_valid = 1'b1; b0.wb_addr = 2'd1; b0.wb_data = 16'h0011;
      #1;
      checks++;
      if (b0.iss_ready !== 1'b1) begin errors++; $display("FAIL iss_wb_r1_ready: got %b want 1", b0.iss_ready); end
      tick();
      b0.iss_valid = 1'b0; b0.wb_valid = 1'b0; b0.rd_addr_a = 2'd1;
      #1;
      checks++;
      if (b0.rd_data_a !== 16'h0011) begin errors++; $display("FAIL iss_wb_r1_data: got %h want 0011", b0.rd_data_a); end
      checks++;
      if (b0.busy_vec !== 4'b0010) begin errors++; $display("FAIL iss_wb_r1_busy_vec: got %b want 0010", b0.busy_vec); end
      checks++;
      if (b0.pending_cnt !== 3'd1) begin errors++; $display("FAIL iss_wb_r1_cnt: got %0d want 1", b0.pending_cnt); end
      checks++;
      if (b0.wb_stray !== 1'b0) begin errors++; $display("FAIL iss_wb_r1_stray: got %b want 0", b0.wb_stray); end
      // Retire the outstanding producer of r1.
      b0.wb_valid = 1'b1; b0.wb_addr = 2'd1; b0.wb_data = 16'h0022;
      tick();
      b0.wb_valid = 1'b0;
      #1;
      checks++;
      if (b0.busy_vec !== 4'b0000) begin errors++; $display("FAIL retire_r1_busy_vec: got %b want 0000", b0.busy_vec); end
      checks++;
      if (b0.rd_data_a !== 16'h0022) begin errors++; $display("FAIL retire_r1_data: got %h want 0022", b0.rd_data_a); end
   endtask

   task automatic test_stray();
      b0.wb_valid = 1'b1; b0.wb_addr = 2'd3; b0.wb_data = 16'h1234;
      tick();
      b0.wb_valid = 1'b0; b0.rd_addr_b = 2'd3;
      #1;
      checks++;
      if (b0.rd_data_b !== 16'h1234) begin errors++; $display("FAIL stray_r3_data: got %h want 1234", b0.rd_data_b); end
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (b0.wb_stray !== 1'b1) begin errors++; $display("FAIL stray_sticky c%0d: got %b want 1", i, b0.wb_stray); end
         tick();
      end
   endtask

   task automatic test_zero_reg();
      bz.wb_valid = 1'b1; bz.wb_addr = 2'd0; bz.wb_data = 16'hFFFF; bz.rd_addr_a = 2'd0;
      #1;
      checks++;
      if (bz.rd_data_a !== 16'h0000) begin errors++; $display("FAIL zero_no_bypass: got %h want 0000", bz.rd_data_a); end
      checks++;
      if (bz.rd_busy_a !== 1'b0) begin errors++; $display("FAIL zero_rd_busy: got %b want 0", bz.rd_busy_a); end
      tick();
      bz.wb_valid = 1'b0;
      #1;
      checks++;
      if (bz.rd_data_a !== 16'h0000) begin errors++; $display("FAIL zero_after_wb: got %h want 0000", bz.rd_data_a); end
      checks++;
      if (bz.wb_stray !== 1'b0) begin errors++; $display("FAIL zero_wb_stray: got %b want 0", bz.wb_stray); end
      bz.iss_valid = 1'b1; bz.iss_addr = 2'd0;
      #1;
      checks++;
      if (bz.iss_ready !== 1'b1) begin errors++; $display("FAIL zero_iss_ready: got %b want 1", bz.iss_ready); end
      tick();
      bz.iss_valid = 1'b0;
      #1;
      checks++;
      if (bz.busy_vec !== 4'b0000) begin errors++; $display("FAIL zero_iss_busy_vec: got %b want 0000", bz.busy_vec); end
      checks++;
      if (bz.pending_cnt !== 3'd0) begin errors++; $display("FAIL zero_iss_cnt: got %0d want 0", bz.pending_cnt); end
      // Non-zero registers still bypass in this build.
      bz.wb_valid = 1'b1; bz.wb_addr = 2'd1; bz.wb_data = 16'h5A5A; bz.rd_addr_b = 2'd1;
      #1;
      checks++;
      if (bz.rd_data_b !== 16'h5A5A) begin errors++; $display("FAIL zero_build_r1_bypass: got %h want 5a5a", bz.rd_data_b); end
      tick();
      bz.wb_valid = 1'b0;
   endtask

   task automatic test_no_bypass();
      bn.iss_valid = 1'b1; bn.iss_addr = 2'd1;
      tick();
      bn.iss_valid = 1'b0;
      bn.wb_valid = 1'b1; bn.wb_addr = 2'd1; bn.wb_data = 16'h00AA; bn.rd_addr_a = 2'd1;
      #1;
      checks++;
      if (bn.rd_data_a !== 16'h0000) begin errors++; $display("FAIL nobypass_same_cycle: got %h want 0000", bn.rd_data_a); end
      checks++;
      if (bn.rd_busy_a !== 1'b1) begin errors++; $display("FAIL nobypass_busy_held: got %b want 1", bn.rd_busy_a); end
      tick();
      bn.wb_valid = 1'b0;
      #1;
      checks++;
      if (bn.rd_data_a !== 16'h00AA) begin errors++; $display("FAIL nobypass_next_cycle: got %h want 00aa", bn.rd_data_a); end
      checks++;
      if (bn.rd_busy_a !== 1'b0) begin errors++; $display("FAIL nobypass_busy_clear: got %b want 0", bn.rd_busy_a); end
      for (int i = 0; i < 4; i++) begin
         bn.iss_valid = 1'b1; bn.iss_addr = 2'(i);
         #1;
         checks++;
         if (bn.iss_ready !== 1'b1) begin errors++; $display("FAIL fill_ready r%0d: got %b want 1", i, bn.iss_ready); end
         tick();
      end
      bn.iss_valid = 1'b0;
      #1;
      checks++;
      if (bn.pending_cnt !== 3'd4) begin errors++; $display("FAIL fill_pending_cnt: got %0d want 4", bn.pending_cnt); end
      checks++;
      if (bn.busy_vec !== 4'b1111) begin errors++; $display("FAIL fill_busy_vec: got %b want 1111", bn.busy_vec); end
   endtask

   initial begin
      reset = 1'b0;
      idle_all();
      test_reset();
      test_issue_writeback();
      test_back_to_back();
      test_stray();
      test_zero_reg();
      test_no_bypass();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
